// File: rtl/u409_tack_pkg.sv
// Shared types and helpers for the U409 cycle-termination sequencer.
package u409_tack_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACK    = 2'd2,
        NEGATE = 2'd3
    } tack_state_e;

    localparam int unsigned TACK_TIMEOUT_DFLT = 125;
    localparam int unsigned MAX_CH            = 16;
    localparam int unsigned MAX_WAIT_W        = 16;
    localparam int unsigned VEC_W             = MAX_CH * MAX_WAIT_W;

    // Extract channel ch's wait_w-bit field from a zero-extended packed wait vector.
    function automatic logic [MAX_WAIT_W-1:0] wait_field(
        input logic [VEC_W-1:0] vec,
        input int unsigned      wait_w,
        input int unsigned      ch
    );
        logic [VEC_W-1:0]      sh;
        logic [MAX_WAIT_W-1:0] mask;
        sh   = vec >> (ch * wait_w);
        mask = MAX_WAIT_W'((32'd1 << wait_w) - 32'd1);
        return sh[MAX_WAIT_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/u409_tack_watchdog.sv
// Watchdog counter for unclaimed/unacknowledged cycles; only built with TACK_TIMEOUT_EN.
`ifdef TACK_TIMEOUT_EN
module u409_tack_watchdog
    import u409_tack_pkg::*;
#(
    parameter int unsigned TIMEOUT = TACK_TIMEOUT_DFLT
) (
    input  logic CLK40,
    input  logic RESET,
    input  logic start,
    input  logic clear,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             run_q;

    // Counter equals the number of edges elapsed since the TS capture edge.
    always_ff @(posedge CLK40) begin
        if (RESET || clear) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            cnt_q <= CNT_W'(1);
            run_q <= 1'b1;
        end else if (run_q && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expire_c = run_q && (cnt_q == CNT_W'(TIMEOUT));

endmodule
`endif

// File: rtl/u409_tack_sequencer.sv
// Shared MC68040/060 TACK/TBI/TCI termination engine for NUM_CH decoded channels.
// Optional watchdog termination is enabled by defining TACK_TIMEOUT_EN.
module u409_tack_sequencer
    import u409_tack_pkg::*;
#(
    parameter int unsigned NUM_CH  = 8,
    parameter int unsigned WAIT_W  = 4,
    parameter int unsigned TIMEOUT = TACK_TIMEOUT_DFLT
) (
    input  logic                                        CLK40,
    input  logic                                        RESET,
    input  logic                                        TSn,
    input  logic [NUM_CH-1:0]                           CH_SEL,
    input  logic [NUM_CH*WAIT_W-1:0]                    CH_WAIT,
    input  logic [NUM_CH-1:0]                           CH_EXT,
    input  logic [NUM_CH-1:0]                           CH_ACK,
    input  logic [NUM_CH-1:0]                           CH_CI,
    output logic                                        TACK_OE,
    output logic                                        TACKn_O,
    output logic                                        TBIn_O,
    output logic                                        TCIn_O,
    output logic                                        BUSY,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ACTIVE_CH,
    output logic                                        TIMEOUT_PULSE
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    tack_state_e       state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              claimed_q, claimed_d;
    logic              ext_q, ext_d;
    logic              ack_smp_q, ack_smp_d;
    logic              oe_q, oe_d;
    logic              tackn_q, tackn_d;
    logic              tbin_q, tbin_d;
    logic              tcin_q, tcin_d;
    logic              busy_q, busy_d;
    logic              pulse_q, pulse_d;
    logic              done_c;
    logic              wd_expire_c;
    logic [CH_W-1:0]   sel_idx_c;

    // Lowest-index asserted CH_SEL bit wins.
    always_comb begin
        sel_idx_c = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (CH_SEL[i]) begin
                sel_idx_c = CH_W'(i);
            end
        end
    end

`ifdef TACK_TIMEOUT_EN
    logic wd_start_c;
    logic wd_clear_c;

    assign wd_start_c = (state_q == IDLE) && !TSn;
    assign wd_clear_c = (state_q == WAIT) && (state_d != WAIT);

    u409_tack_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .CLK40    (CLK40),
        .RESET    (RESET),
        .start    (wd_start_c),
        .clear    (wd_clear_c),
        .expire_c (wd_expire_c)
    );
`else
    // No watchdog in this build; TIMEOUT has no effect.
    assign wd_expire_c = (TIMEOUT == 0) && 1'b0;
`endif

    // Next state, datapath loads and next registered output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        claimed_d = claimed_q;
        ext_d     = ext_q;
        ack_smp_d = 1'b0;
        done_c    = 1'b0;
        oe_d      = 1'b0;
        tackn_d   = 1'b1;
        tbin_d    = 1'b1;
        tcin_d    = 1'b1;
        busy_d    = 1'b0;
        pulse_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!TSn) begin
                    state_d   = WAIT;
                    ch_d      = sel_idx_c;
                    claimed_d = |CH_SEL;
                    ext_d     = (|CH_SEL) & CH_EXT[sel_idx_c];
                    cnt_d     = WAIT_W'(wait_field(VEC_W'(CH_WAIT), WAIT_W, 32'(sel_idx_c)));
                end
            end
            WAIT: begin
                // External acknowledge is registered once before it terminates the cycle.
                ack_smp_d = CH_ACK[ch_q];
                if (ext_q) begin
                    done_c = claimed_q && ack_smp_q;
                end else begin
                    done_c = claimed_q && (cnt_q == '0);
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - WAIT_W'(1);
                    end
                end
                if (done_c) begin
                    state_d = ACK;
                end else if (wd_expire_c) begin
                    state_d = ACK;
                    pulse_d = 1'b1;
                end
            end
            ACK:     state_d = NEGATE;
            NEGATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        if (state_d == ACK) begin
            oe_d    = 1'b1;
            tackn_d = 1'b0;
            tbin_d  = 1'b0;
            tcin_d  = ~(claimed_q & CH_CI[ch_q]);
        end else if (state_d == NEGATE) begin
            oe_d    = 1'b1;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK40) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            claimed_q <= 1'b0;
            ext_q     <= 1'b0;
            ack_smp_q <= 1'b0;
            oe_q      <= 1'b0;
            tackn_q   <= 1'b1;
            tbin_q    <= 1'b1;
            tcin_q    <= 1'b1;
            busy_q    <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            claimed_q <= claimed_d;
            ext_q     <= ext_d;
            ack_smp_q <= ack_smp_d;
            oe_q      <= oe_d;
            tackn_q   <= tackn_d;
            tbin_q    <= tbin_d;
            tcin_q    <= tcin_d;
            busy_q    <= busy_d;
            pulse_q   <= pulse_d;
        end
    end

    assign TACK_OE       = oe_q;
    assign TACKn_O       = tackn_q;
    assign TBIn_O        = tbin_q;
    assign TCIn_O        = tcin_q;
    assign BUSY          = busy_q;
    assign ACTIVE_CH     = ch_q;
    assign TIMEOUT_PULSE = pulse_q;

endmodule
